// File: rtl/serial_read_buffer_pkg.sv
// rtl/serial_read_buffer_pkg.sv - shared helpers for the serial read buffer
// Purpose: width and count-clamping helpers used by the buffer and its interface.
// Ports: none (package).
package serial_read_buffer_pkg;

  // Width needed to hold any count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Requests longer than the buffer collapse to a full-buffer read.
  function automatic int unsigned clamp_count(input int unsigned cnt, input int unsigned max_cnt);
    return (cnt > max_cnt) ? max_cnt : cnt;
  endfunction

endpackage

// File: rtl/serial_read_buffer_if.sv
// rtl/serial_read_buffer_if.sv - request/strobe/result bundle of the serial read buffer
// Purpose: groups the read request, sample strobe, serial bit and result signals.
// Ports (signals): start, read_sig, in_line, read_count -> buffer; data_out, done_sig <- buffer.
// Modports: master drives requests and strobes, slave is the buffer itself.
interface serial_read_buffer_if
  import serial_read_buffer_pkg::*;
#(
  parameter int BUF_SIZE = 8
);
  localparam int CNT_W = cnt_width(BUF_SIZE);

  logic                start;
  logic                read_sig;
  logic                in_line;
  logic [CNT_W-1:0]    read_count;
  logic [BUF_SIZE-1:0] data_out;
  logic                done_sig;

  modport master (
    output start, read_sig, in_line, read_count,
    input  data_out, done_sig
  );

  modport slave (
    input  start, read_sig, in_line, read_count,
    output data_out, done_sig
  );

endinterface

// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - synchronised single-cycle edge detector
// Purpose: turns an asynchronous level into one sys_clk-wide pulse per qualifying edge.
// Ports: sys_clk (in) clock; sig (in) raw level; edge_sig (out) one-cycle edge pulse.
// FALL_EDGE=0 detects rising edges, FALL_EDGE=1 detects falling edges.
module edge_detector #(
  parameter bit FALL_EDGE = 1'b0
) (
  input  logic sys_clk,
  input  logic sig,
  output logic edge_sig
);

  // No reset: registers power up at 0 so a line idling high after power-up
  // produces a single rising-edge pulse once it propagates.
  logic sync1_q = 1'b0;
  logic sync2_q = 1'b0;
  logic prev_q  = 1'b0;

  always_ff @(posedge sys_clk) begin
    sync1_q <= sig;
    sync2_q <= sync1_q;
    prev_q  <= sync2_q;
  end

  assign edge_sig = FALL_EDGE ? (prev_q & ~sync2_q) : (sync2_q & ~prev_q);

endmodule

// File: rtl/serial_read_buffer.sv
// rtl/serial_read_buffer.sv - counted serial-to-parallel read buffer
// Purpose: on start, captures read_count serial bits (one per read_sig strobe) and
//          publishes them on data_out when the count is reached.
// Ports: sys_clk (in) clock; rst (in) synchronous active-high reset;
//        bus (slave) start/read_sig/in_line/read_count in, data_out/done_sig out.
module serial_read_buffer
  import serial_read_buffer_pkg::*;
#(
  parameter int BUF_SIZE  = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  serial_read_buffer_if.slave   bus
);

  localparam int CNT_W = cnt_width(BUF_SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    target_q, target_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    bit_cnt_inc;
  logic [BUF_SIZE-1:0] shift_q, shift_d;
  logic [BUF_SIZE-1:0] shift_in;
  logic [BUF_SIZE-1:0] data_q, data_d;

  assign bit_cnt_inc = bit_cnt_q + 1'b1;

  // Shift register value if the current strobe is captured. LSB-first places
  // bit k at index k; MSB-first shifts left so the word ends up right-aligned.
  always_comb begin
    shift_in = shift_q;
    if (LSB_FIRST) begin
      shift_in = shift_q | ({{(BUF_SIZE-1){1'b0}}, bus.in_line} << bit_cnt_q);
    end else begin
      shift_in = {shift_q[BUF_SIZE-2:0], bus.in_line};
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        // read_sig is deliberately not looked at here, even alongside start.
        if (bus.start) begin
          target_d  = CNT_W'(clamp_count(32'(bus.read_count), 32'(BUF_SIZE)));
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = READ;
        end
      end
      READ: begin
        if (target_q == '0) begin
          // Zero-length read: shift register was cleared on start, so this publishes 0.
          data_d  = shift_q;
          state_d = IDLE;
        end else if (bus.read_sig) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_inc == target_q) begin
            data_d  = shift_in;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.done_sig = (state_q == IDLE);

endmodule

// File: tb/tb_serial_read_buffer.sv
// tb/tb_serial_read_buffer.sv - scoreboard bench for serial_read_buffer (MSB- and LSB-first)
`timescale 1ns/1ps
module tb_serial_read_buffer;

  localparam int BUF_SIZE = 8;
  localparam int CNT_W    = 4;

  logic             sys_clk = 1'b0;
  logic             rst;
  logic             start;
  logic             man_strobe;
  logic             manual;
  logic             in_line;
  logic             ser_clk;
  logic [CNT_W-1:0] read_count;
  logic             ed_pulse;
  logic             read_sig;

  always #41.667 sys_clk = ~sys_clk;

  edge_detector #(.FALL_EDGE(1'b0)) u_ed (
    .sys_clk  (sys_clk),
    .sig      (ser_clk),
    .edge_sig (ed_pulse)
  );

  assign read_sig = manual ? man_strobe : ed_pulse;

  serial_read_buffer_if #(.BUF_SIZE(BUF_SIZE)) bus_msb ();
  serial_read_buffer_if #(.BUF_SIZE(BUF_SIZE)) bus_lsb ();

  assign bus_msb.start      = start;
  assign bus_msb.read_sig   = read_sig;
  assign bus_msb.in_line    = in_line;
  assign bus_msb.read_count = read_count;
  assign bus_lsb.start      = start;
  assign bus_lsb.read_sig   = read_sig;
  assign bus_lsb.in_line    = in_line;
  assign bus_lsb.read_count = read_count;

  serial_read_buffer #(.BUF_SIZE(BUF_SIZE), .LSB_FIRST(1'b0)) u_msb (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus_msb.slave)
  );

  serial_read_buffer #(.BUF_SIZE(BUF_SIZE), .LSB_FIRST(1'b1)) u_lsb (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus_lsb.slave)
  );

  typedef struct {
    logic [7:0] data;
    bit         lat;
  } exp_t;

  exp_t sb_q[2][$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_strobe = 0;
  bit   mon_en = 1'b0;
  logic done_prev[2] = '{1'b1, 1'b1};
  bit   seq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input bit b[$], input int cnt, input bit lsb);
    int n;
    logic [7:0] r;
    n = (cnt > BUF_SIZE) ? BUF_SIZE : cnt;
    r = '0;
    for (int k = 0; k < n && k < b.size(); k++) begin
      if (b[k]) begin
        if (lsb) r = r | (8'd1 << k);
        else     r = r | (8'd1 << (n - 1 - k));
      end
    end
    return r;
  endfunction

  task automatic push_exp(input bit b[$], input int cnt, input bit lat);
    exp_t e;
    e.lat  = lat;
    e.data = model(b, cnt, 1'b0);
    sb_q[0].push_back(e);
    e.data = model(b, cnt, 1'b1);
    sb_q[1].push_back(e);
  endtask

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (read_sig === 1'b1) last_strobe <= cyc + 1;
  end

  always @(negedge sys_clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        logic       dn;
        logic [7:0] dv;
        dn = (d == 0) ? bus_msb.done_sig : bus_lsb.done_sig;
        dv = (d == 0) ? bus_msb.data_out : bus_lsb.data_out;
        if (dn === 1'b1 && done_prev[d] !== 1'b1) begin
          if (sb_q[d].size() == 0) begin
            check($sformatf("sb_unexpected_done%0d", d), 32'd1, 32'd0);
          end else begin
            mon_e = sb_q[d].pop_front();
            check($sformatf("sb_data%0d", d), 32'(dv), 32'(mon_e.data));
            if (mon_e.lat) check($sformatf("sb_latency%0d", d), 32'(cyc - last_strobe + 1), 32'd1);
          end
        end
        done_prev[d] = dn;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_start(input int cnt);
    start      = 1'b1;
    read_count = CNT_W'(cnt);
    tick();
    start = 1'b0;
    check("busy_msb", 32'(bus_msb.done_sig), 32'd0);
    check("busy_lsb", 32'(bus_lsb.done_sig), 32'd0);
  endtask

  task automatic strobe(input bit b);
    man_strobe = 1'b1;
    in_line    = b;
    tick();
    man_strobe = 1'b0;
    tick();
  endtask

  task automatic ser_bit(input bit b);
    in_line = b;
    ser_clk = 1'b0;
    tick(4);
    ser_clk = 1'b1;
    tick(4);
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 100 && !(bus_msb.done_sig === 1'b1 && bus_lsb.done_sig === 1'b1); i++) tick();
    check(tag, 32'(bus_msb.done_sig & bus_lsb.done_sig), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; man_strobe = 1'b0; manual = 1'b1;
    in_line = 1'b0; ser_clk = 1'b0; read_count = '0;
    tick(3);
    rst = 1'b0;
    tick();
    check("rst_data_msb", 32'(bus_msb.data_out), 32'h00);
    check("rst_data_lsb", 32'(bus_lsb.data_out), 32'h00);
    check("rst_done_msb", 32'(bus_msb.done_sig), 32'd1);
    check("rst_done_lsb", 32'(bus_lsb.done_sig), 32'd1);
    mon_en = 1'b1;

    // 8-bit read through the edge detector
    manual = 1'b0;
    seq = '{0, 0, 1, 1, 1, 0, 1, 0};
    push_exp(seq, 8, 1'b1);
    do_start(8);
    foreach (seq[k]) ser_bit(seq[k]);
    wait_done("done_8bit");

    // 8-bit read, manual strobes, LSB-first pattern
    manual = 1'b1;
    seq = '{0, 1, 0, 1, 1, 1, 0, 0};
    push_exp(seq, 8, 1'b1);
    do_start(8);
    foreach (seq[k]) strobe(seq[k]);
    wait_done("done_lsb8");

    // 4-bit read through the edge detector
    manual = 1'b0;
    seq = '{1, 1, 1, 1};
    push_exp(seq, 4, 1'b1);
    do_start(4);
    foreach (seq[k]) ser_bit(seq[k]);
    wait_done("done_4bit");
    manual = 1'b1;

    // Reset mid-transfer aborts and clears
    seq = '{};
    push_exp(seq, 0, 1'b0);
    do_start(6);
    strobe(1); strobe(0); strobe(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_done", 32'(bus_msb.done_sig & bus_lsb.done_sig), 32'd1);
    check("abort_data", 32'({bus_msb.data_out, bus_lsb.data_out}), 32'h0);
    strobe(0); strobe(1); strobe(0);
    check("abort_ignore", 32'({bus_msb.data_out, bus_lsb.data_out}), 32'h0);

    // Over-long count clamps to the buffer width
    seq = '{};
    seq.push_back(1'b1);
    for (int k = 0; k < 9; k++) seq.push_back(bit'($urandom_range(1, 0)));
    push_exp(seq, 15, 1'b1);
    do_start(15);
    for (int k = 0; k < 8; k++) strobe(seq[k]);
    check("clamp_done", 32'(bus_msb.done_sig & bus_lsb.done_sig), 32'd1);
    strobe(seq[8]); strobe(seq[9]);
    check("clamp_hold_msb", 32'(bus_msb.data_out), 32'(model(seq, 15, 1'b0)));
    check("clamp_hold_lsb", 32'(bus_lsb.data_out), 32'(model(seq, 15, 1'b1)));

    // Zero-length read publishes zero
    seq = '{};
    push_exp(seq, 0, 1'b0);
    do_start(0);
    tick();
    check("zero_done", 32'(bus_msb.done_sig & bus_lsb.done_sig), 32'd1);

    // start during READ is ignored
    seq = '{1, 0, 1, 1};
    push_exp(seq, 4, 1'b1);
    do_start(4);
    strobe(1); strobe(0);
    start = 1'b1; read_count = 4'd2;
    tick();
    start = 1'b0;
    strobe(1);
    check("start_in_read", 32'(bus_msb.done_sig | bus_lsb.done_sig), 32'd0);
    strobe(1);
    wait_done("done_restart");

    // Strobes in IDLE do nothing
    strobe(1); strobe(1);
    check("idle_hold_msb", 32'(bus_msb.data_out), 32'(model(seq, 4, 1'b0)));
    check("idle_hold_done", 32'(bus_msb.done_sig & bus_lsb.done_sig), 32'd1);

    // start coincident with a strobe: that strobe is not captured
    seq = '{0, 1, 0};
    push_exp(seq, 3, 1'b1);
    start = 1'b1; read_count = 4'd3; man_strobe = 1'b1; in_line = 1'b1;
    tick();
    start = 1'b0; man_strobe = 1'b0;
    tick();
    check("coinc_busy", 32'(bus_msb.done_sig | bus_lsb.done_sig), 32'd0);
    foreach (seq[k]) strobe(seq[k]);
    wait_done("done_coinc");

    for (int i = 0; i < 50 && (sb_q[0].size() + sb_q[1].size()) != 0; i++) tick();
    check("sb_drain", 32'(sb_q[0].size() + sb_q[1].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
